// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and request decode helpers for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} lsu_state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_MISALIGN = 2'd1,
      ERR_ILLEGAL  = 2'd2,
      ERR_TIMEOUT  = 2'd3
   } lsu_err_e;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   function automatic logic is_illegal(input logic load, input logic store, input logic [2:0] f3);
      if (load == store) return 1'b1;
      if (load) return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      return f3 >= 3'd3;
   endfunction

   // Only meaningful for legal requests; halfword encodings share f3[1:0]==1 for load and store.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
      if (f3[1:0] == 2'd1) return addr_lo[0];
      if (f3 == 3'd2) return addr_lo != 2'd0;
      return 1'b0;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables and replicated store data,
// plus load lane extraction with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic        store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_al,
   output logic [31:0] rdata_ext
);

   logic [31:0] shifted;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign shifted = rdata >> {addr_lo, 3'b000};
   assign lane_b  = shifted[7:0];
   assign lane_h  = addr_lo[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      be       = 4'b1111;
      wdata_al = wdata;
      if (store) begin
         case (funct3)
            F3_SB: begin
               be       = 4'b0001 << addr_lo;
               wdata_al = {4{wdata[7:0]}};
            end
            F3_SH: begin
               be       = 4'b0011 << {addr_lo[1], 1'b0};
               wdata_al = {2{wdata[15:0]}};
            end
            default: begin
               be       = 4'b1111;
               wdata_al = wdata;
            end
         endcase
      end
   end

   always_comb begin
      rdata_ext = '0;
      case (funct3)
         F3_LB:   rdata_ext = {{24{lane_b[7]}}, lane_b};
         F3_LH:   rdata_ext = {{16{lane_h[15]}}, lane_h};
         F3_LW:   rdata_ext = rdata;
         F3_LBU:  rdata_ext = {24'd0, lane_b};
         F3_LHU:  rdata_ext = {16'd0, lane_h};
         default: rdata_ext = '0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding RV32I load/store controller in front of the data RAM, with handshake timeout.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned halfword/word accesses without touching the RAM.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int AddressSize   = 32,
   parameter int WordSize      = 32,
   parameter int TimeoutCycles = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic                   req_load_i,
   input  logic                   req_store_i,
   input  logic [2:0]             req_funct3_i,
   input  logic [AddressSize-1:0] req_addr_i,
   input  logic [WordSize-1:0]    req_wdata_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [WordSize-1:0]    rsp_rdata_o,
   output logic                   rsp_err_o,
   output logic [1:0]             rsp_err_code_o,
   output logic [AddressSize-1:0] mem_addr_o,
   output logic [WordSize-1:0]    mem_wdata_o,
   output logic                   mem_re_o,
   output logic                   mem_we_o,
   output logic [3:0]             mem_be_o,
   input  logic [WordSize-1:0]    mem_rdata_i,
   input  logic                   mem_read_valid_i,
   input  logic                   mem_write_ready_i
);

   localparam int CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

   lsu_state_e state, state_next;

   logic                   load_q, store_q;
   logic [2:0]             funct3_q;
   logic [AddressSize-1:0] addr_q;
   logic [WordSize-1:0]    wdata_q;
   logic [CntW-1:0]        cnt_q;
   logic [WordSize-1:0]    rsp_rdata_q;
   lsu_err_e               rsp_code_q;

   logic       req_illegal, req_misal, acc_done, timed_out;
   lsu_err_e   req_code;
   logic [3:0]          be_al;
   logic [WordSize-1:0] wdata_al, rdata_ext;

   assign req_illegal = is_illegal(req_load_i, req_store_i, req_funct3_i);
`ifdef LSU_MISALIGN_CHECK_EN
   assign req_misal = is_misaligned(req_funct3_i, req_addr_i[1:0]);
`else
   assign req_misal = 1'b0;
`endif
   assign req_code  = req_illegal ? ERR_ILLEGAL : (req_misal ? ERR_MISALIGN : ERR_NONE);
   assign acc_done  = (load_q && mem_read_valid_i) || (store_q && mem_write_ready_i);
   assign timed_out = (cnt_q == CntMax);

   lsu_align u_align (
      .store     (store_q),
      .funct3    (funct3_q),
      .addr_lo   (addr_q[1:0]),
      .wdata     (wdata_q),
      .rdata     (mem_rdata_i),
      .be        (be_al),
      .wdata_al  (wdata_al),
      .rdata_ext (rdata_ext)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req_valid_i) state_next = (req_code != ERR_NONE) ? DONE : ACCESS;
         ACCESS:  if (acc_done || timed_out) state_next = DONE;
         DONE:    if (rsp_ready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         load_q      <= 1'b0;
         store_q     <= 1'b0;
         funct3_q    <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         rsp_rdata_q <= '0;
         rsp_code_q  <= ERR_NONE;
      end else begin
         case (state)
            IDLE: if (req_valid_i) begin
               load_q      <= req_load_i;
               store_q     <= req_store_i;
               funct3_q    <= req_funct3_i;
               addr_q      <= req_addr_i;
               wdata_q     <= req_wdata_i;
               cnt_q       <= '0;
               rsp_rdata_q <= '0;
               rsp_code_q  <= req_code;
            end
            ACCESS: begin
               if (load_q && mem_read_valid_i) begin
                  rsp_rdata_q <= rdata_ext;
               end else if (!acc_done) begin
                  if (timed_out) rsp_code_q <= ERR_TIMEOUT;
                  else           cnt_q      <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Everything is gated by rst so a write in flight is squashed in the cycle reset is seen.
   always_comb begin
      req_ready_o    = !rst && (state == IDLE);
      rsp_valid_o    = !rst && (state == DONE);
      rsp_rdata_o    = rst ? '0 : rsp_rdata_q;
      rsp_err_code_o = rst ? 2'd0 : rsp_code_q;
      rsp_err_o      = !rst && (rsp_code_q != ERR_NONE);
      mem_addr_o     = '0;
      mem_wdata_o    = '0;
      mem_be_o       = '0;
      mem_re_o       = 1'b0;
      mem_we_o       = 1'b0;
      if (!rst && state == ACCESS) begin
         mem_addr_o  = {addr_q[AddressSize-1:2], 2'b00};
         mem_wdata_o = wdata_al;
         mem_be_o    = be_al;
         mem_re_o    = load_q;
         mem_we_o    = store_q;
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with hand-computed expectations.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i, req_ready_o, req_load_i, req_store_i;
   logic [2:0]  req_funct3_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic [1:0]  rsp_err_code_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic        mem_re_o, mem_we_o, mem_read_valid_i, mem_write_ready_i;
   logic [3:0]  mem_be_o;

   int vectors = 0;
   int miscompares = 0;

   lsu_mem_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_load_i(req_load_i), .req_store_i(req_store_i),
      .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o), .rsp_err_code_o(rsp_err_code_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_rdata_i(mem_rdata_i), .mem_read_valid_i(mem_read_valid_i),
      .mem_write_ready_i(mem_write_ready_i)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one request for a single cycle; returns in the first ACCESS (or DONE) cycle.
   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
      req_valid_i  = 1'b1;
      req_load_i   = ld;
      req_store_i  = st;
      req_funct3_i = f3;
      req_addr_i   = addr;
      req_wdata_i  = wd;
      step();
      req_valid_i  = 1'b0;
   endtask

   task automatic release_rsp();
      rsp_ready_i = 1'b1;
      step();
      rsp_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      vectors++;
      if ({req_ready_o, rsp_valid_o, rsp_err_o, mem_re_o, mem_we_o} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_ctl: got %b want 00000",
                  {req_ready_o, rsp_valid_o, rsp_err_o, mem_re_o, mem_we_o});
      end
      vectors++;
      if ({rsp_rdata_o, mem_addr_o, mem_wdata_o, mem_be_o, rsp_err_code_o} !== 102'b0) begin
         miscompares++;
         $display("FAIL reset_data: rdata %h addr %h wdata %h be %b code %0d all want 0",
                  rsp_rdata_o, mem_addr_o, mem_wdata_o, mem_be_o, rsp_err_code_o);
      end
      rst = 1'b0;
      step();
      vectors++;
      if (req_ready_o !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: got %b want 1", req_ready_o);
      end
   endtask

   task automatic test_store_byte();
      mem_write_ready_i = 1'b1;
      issue(1'b0, 1'b1, 3'd0, 32'h103, 32'h0000_00AB);
      vectors++;
      if ({mem_we_o, mem_re_o, mem_be_o} !== 6'b10_1000) begin
         miscompares++;
         $display("FAIL sb_ctl: got we%b re%b be%b want we1 re0 be1000", mem_we_o, mem_re_o, mem_be_o);
      end
      vectors++;
      if (mem_wdata_o !== 32'hABAB_ABAB || mem_addr_o !== 32'h100) begin
         miscompares++;
         $display("FAIL sb_data: got wdata %h addr %h want ABABABAB 00000100", mem_wdata_o, mem_addr_o);
      end
      vectors++;
      if (rsp_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL sb_early: rsp_valid %b want 0 at N+1", rsp_valid_o);
      end
      step();
      vectors++;
      if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin
         miscompares++;
         $display("FAIL sb_rsp: got valid %b err %b rdata %h want 1 0 0", rsp_valid_o, rsp_err_o, rsp_rdata_o);
      end
      vectors++;
      if (mem_we_o !== 1'b0) begin
         miscompares++;
         $display("FAIL sb_we_done: got %b want 0", mem_we_o);
      end
      release_rsp();
      mem_write_ready_i = 1'b0;
   endtask

   task automatic test_loads();
      logic [2:0]  f3  [4] = '{3'd0, 3'd4, 3'd1, 3'd2};
      logic [31:0] ad  [4] = '{32'h102, 32'h102, 32'h102, 32'h100};
      logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h80FF_7F01};
      mem_read_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         issue(1'b1, 1'b0, f3[i], ad[i], 32'h0);
         vectors++;
         if (mem_re_o !== 1'b1 || mem_be_o !== 4'b1111 || mem_we_o !== 1'b0) begin
            miscompares++;
            $display("FAIL load%0d_ctl: got re%b we%b be%b want re1 we0 be1111", i, mem_re_o, mem_we_o, mem_be_o);
         end
         step();
         vectors++;
         if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== exp[i] || rsp_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL load%0d_rsp: got valid %b rdata %h err %b want 1 %h 0",
                     i, rsp_valid_o, rsp_rdata_o, rsp_err_o, exp[i]);
         end
         release_rsp();
      end
   endtask

   task automatic test_read_wait();
      mem_read_valid_i = 1'b0;
      issue(1'b1, 1'b0, 3'd2, 32'h100, 32'h0);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (mem_re_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL wait%0d: got re %b valid %b want 1 0", i, mem_re_o, rsp_valid_o);
         end
         step();
      end
      mem_read_valid_i = 1'b1;
      vectors++;
      if (mem_re_o !== 1'b1) begin
         miscompares++;
         $display("FAIL wait_4th: got re %b want 1", mem_re_o);
      end
      step();
      vectors++;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h80FF_7F01) begin
         miscompares++;
         $display("FAIL wait_rsp: got valid %b rdata %h want 1 80ff7f01", rsp_valid_o, rsp_rdata_o);
      end
      release_rsp();
   endtask

   task automatic test_timeout();
      int acc = 0;
      int cyc = 0;
      mem_write_ready_i = 1'b0;
      issue(1'b0, 1'b1, 3'd2, 32'h200, 32'h1234_5678);
      while (rsp_valid_o !== 1'b1 && cyc < 40) begin
         if (mem_we_o === 1'b1) acc++;
         step();
         cyc++;
      end
      vectors++;
      if (acc != 16 || rsp_valid_o !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_cycles: got %0d access cycles valid %b want 16 1", acc, rsp_valid_o);
      end
      vectors++;
      if (rsp_err_o !== 1'b1 || rsp_err_code_o !== 2'd3 || rsp_rdata_o !== 32'h0) begin
         miscompares++;
         $display("FAIL timeout_rsp: got err %b code %0d rdata %h want 1 3 0", rsp_err_o, rsp_err_code_o, rsp_rdata_o);
      end
      release_rsp();
   endtask

   task automatic test_misalign();
      mem_read_valid_i = 1'b1;
      issue(1'b1, 1'b0, 3'd2, 32'h101, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
      vectors++;
      if (rsp_valid_o !== 1'b1 || rsp_err_code_o !== 2'd1 || rsp_err_o !== 1'b1 || mem_re_o !== 1'b0) begin
         miscompares++;
         $display("FAIL misalign: got valid %b err %b code %0d re %b want 1 1 1 0",
                  rsp_valid_o, rsp_err_o, rsp_err_code_o, mem_re_o);
      end
`else
      vectors++;
      if (mem_re_o !== 1'b1 || mem_addr_o !== 32'h100) begin
         miscompares++;
         $display("FAIL misalign_acc: got re %b addr %h want 1 00000100", mem_re_o, mem_addr_o);
      end
      step();
      vectors++;
      if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h80FF_7F01) begin
         miscompares++;
         $display("FAIL misalign_rsp: got valid %b err %b rdata %h want 1 0 80ff7f01",
                  rsp_valid_o, rsp_err_o, rsp_rdata_o);
      end
`endif
      release_rsp();
   endtask

   task automatic test_illegal();
      logic       ld [2] = '{1'b1, 1'b1};
      logic       st [2] = '{1'b1, 1'b0};
      logic [2:0] f3 [2] = '{3'd2, 3'd3};
      for (int i = 0; i < 2; i++) begin
         issue(ld[i], st[i], f3[i], 32'h100, 32'h0);
         vectors++;
         if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_err_code_o !== 2'd2 ||
             mem_re_o !== 1'b0 || mem_we_o !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal%0d: got valid %b err %b code %0d re %b we %b want 1 1 2 0 0",
                     i, rsp_valid_o, rsp_err_o, rsp_err_code_o, mem_re_o, mem_we_o);
         end
         release_rsp();
      end
   endtask

   task automatic test_rst_mid();
      mem_write_ready_i = 1'b0;
      issue(1'b0, 1'b1, 3'd2, 32'h300, 32'h1234_5678);
      step();
      vectors++;
      if (mem_we_o !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_pre: got we %b want 1", mem_we_o);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (mem_we_o !== 1'b0 || req_ready_o !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_we: got we %b ready %b want 0 0", mem_we_o, req_ready_o);
      end
      step();
      rst = 1'b0;
      step();
      vectors++;
      if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || mem_we_o !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_after: got ready %b valid %b we %b want 1 0 0", req_ready_o, rsp_valid_o, mem_we_o);
      end
   endtask

   task automatic test_backpressure();
      mem_read_valid_i = 1'b1;
      issue(1'b1, 1'b0, 3'd1, 32'h100, 32'h0);
      step();
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0000_7F01 || rsp_err_o !== 1'b0 || req_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL hold%0d: got valid %b rdata %h err %b ready %b want 1 00007f01 0 0",
                     i, rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o);
         end
         step();
      end
      release_rsp();
      vectors++;
      if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_release: got ready %b valid %b want 1 0", req_ready_o, rsp_valid_o);
      end
   endtask

   assign mem_rdata_i = (mem_addr_o == 32'h100) ? 32'h80FF_7F01 : 32'hDEAD_BEEF;

   initial begin
      req_valid_i = 0; req_load_i = 0; req_store_i = 0; req_funct3_i = 0;
      req_addr_i = 0; req_wdata_i = 0; rsp_ready_i = 0;
      mem_read_valid_i = 0; mem_write_ready_i = 0; rst = 1;
      #2;
      test_reset();
      test_store_byte();
      test_loads();
      test_read_wait();
      test_timeout();
      test_misalign();
      test_illegal();
      test_rst_mid();
      test_backpressure();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
